// File: rtl/pll_reset_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam int DEF_LOCK_FILTER = 16;
  localparam int DEF_HOLD_CYCLES = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two-stage capture; both stages clear on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pll_reset_ctrl.sv
// Reset sequencer and divided clock-enable generator behind the system PLL.
// Optional PLL_RESET_SOFT_EN adds a soft_reset input that re-enters HOLD.
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
`ifdef PLL_RESET_SOFT_EN
  input  logic       soft_reset,
`endif
  output logic       sys_reset,
  output logic       cen_half,
  output logic       cen_quarter,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_W = $clog2(max_int(LOCK_FILTER, HOLD_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LF_LAST   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [1:0]       div_r;
  logic [1:0]       div_nxt_s;
  logic             sys_reset_r;
  logic             cen_half_r;
  logic             cen_quarter_r;
  logic [7:0]       loss_cnt_r;
  logic             lost_s;
  logic             lock_s;
  logic             soft_s;

  bit_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

`ifdef PLL_RESET_SOFT_EN
  assign soft_s = soft_reset;
`else
  assign soft_s = 1'b0;
`endif

  // Sequencing rules; loss of lock outranks soft reset
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    lost_s      = 1'b0;
    case (state_r)
      WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_nxt_s = '0;
        end else if (cnt_r == LF_LAST) begin
          state_nxt_s = HOLD;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = '0;
          lost_s      = 1'b1;
        end else if (soft_s) begin
          cnt_nxt_s = '0;
        end else if (cnt_r == HOLD_LAST) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = '0;
          lost_s      = 1'b1;
        end else if (soft_s) begin
          state_nxt_s = HOLD;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = WAIT_LOCK;
        cnt_nxt_s   = '0;
      end
    endcase

    // Divider only advances across consecutive RUN cycles, so the first RUN cycle sees div=0
    if ((state_r == RUN) && (state_nxt_s == RUN)) begin
      div_nxt_s = div_r + 2'd1;
    end else begin
      div_nxt_s = 2'd0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= WAIT_LOCK;
      cnt_r         <= '0;
      div_r         <= 2'd0;
      sys_reset_r   <= 1'b1;
      cen_half_r    <= 1'b0;
      cen_quarter_r <= 1'b0;
      loss_cnt_r    <= 8'd0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      div_r         <= div_nxt_s;
      sys_reset_r   <= (state_nxt_s != RUN);
      cen_half_r    <= (state_nxt_s == RUN) && div_nxt_s[0];
      cen_quarter_r <= (state_nxt_s == RUN) && (div_nxt_s == 2'd3);
      if (lost_s && (loss_cnt_r != 8'hFF)) begin
        loss_cnt_r <= loss_cnt_r + 8'd1;
      end else begin
        loss_cnt_r <= loss_cnt_r;
      end
    end
  end

  assign sys_reset     = sys_reset_r;
  assign cen_half      = cen_half_r;
  assign cen_quarter   = cen_quarter_r;
  assign lock_loss_cnt = loss_cnt_r;

endmodule
